// File: rtl/conf_pkt_packer.sv
// Collects register writes into a FIFO and packs them into configuration packets, merged at
// packet boundaries with a pass-through packet stream behind a 1-deep output register.
module conf_pkt_packer #(
  parameter int unsigned  MAX_WR     = 16,
  parameter int unsigned  FIFO_DEPTH = 32,
  parameter int unsigned  TIMEOUT    = 64,
  parameter logic [127:0] CONF_HEAD  = {48'h8888_8888_8988, 48'h0102_0304_0506, 16'h9006, 16'h0}
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_wr_valid,
  output logic                        o_wr_ready,
  input  logic [31:0]                 i_wr_addr,
  input  logic [31:0]                 i_wr_data,
  input  logic                        i_flush,
  input  logic                        i_pkt_valid,
  input  logic [133:0]                i_pkt,
  output logic                        o_pkt_ready,
  output logic                        o_data_valid,
  output logic [133:0]                o_data,
  input  logic                        i_data_ready,
  output logic [$clog2(FIFO_DEPTH):0] o_fifo_cnt,
  output logic [15:0]                 o_conf_cnt,
  output logic [15:0]                 o_drop_cnt
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StPass, StConfHead, StConfBody} state_e;

  state_e        state_q;
  logic [63:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0] wptr_q, rptr_q;
  logic [TW-1:0] to_q;
  logic [7:0]    rem_q;
  logic          flush_q;

  logic          free, push, pop, nonempty, trigger;
  logic [1:0]    pkt_tag;
  logic [7:0]    n_load;
  logic [133:0]  body_beat;

  always_comb begin
    free      = !o_data_valid || i_data_ready;
    nonempty  = (o_fifo_cnt != '0);
    o_wr_ready = (o_fifo_cnt < DEPTH_C);
    push      = i_wr_valid && o_wr_ready;
    pop       = (state_q == StConfBody) && free;
    pkt_tag   = i_pkt[133:132];
    // A write landing in the firing cycle restarts the timeout instead of triggering it.
    trigger   = (32'(o_fifo_cnt) >= MAX_WR) || (flush_q && nonempty) ||
                ((to_q == TO_LAST) && nonempty && !push);
    n_load    = (32'(o_fifo_cnt) >= MAX_WR) ? 8'(MAX_WR) : 8'(o_fifo_cnt);
    body_beat = {(rem_q == 8'd1) ? 2'b10 : 2'b00, 4'hf, 48'h0, mem_q[rptr_q], 16'h0};
    o_pkt_ready = 1'b0;
    case (state_q)
      StIdle:  o_pkt_ready = i_pkt_valid && (pkt_tag != 2'b01);
      StPass:  o_pkt_ready = free;
      default: o_pkt_ready = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= StIdle;
      wptr_q       <= '0;
      rptr_q       <= '0;
      o_fifo_cnt   <= '0;
      to_q         <= '0;
      rem_q        <= '0;
      flush_q      <= 1'b0;
      o_data_valid <= 1'b0;
      o_data       <= '0;
      o_conf_cnt   <= '0;
      o_drop_cnt   <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (push) begin
        mem_q[wptr_q] <= {i_wr_data, i_wr_addr};
        wptr_q        <= wptr_q + AW'(1);
      end
      if (pop) rptr_q <= rptr_q + AW'(1);
      o_fifo_cnt <= o_fifo_cnt + CW'(push) - CW'(pop);

      if (push || !nonempty || state_q == StConfHead || state_q == StConfBody) begin
        to_q <= '0;
      end else if (to_q != TO_LAST) begin
        to_q <= to_q + TW'(1);
      end

      if (state_q == StIdle && trigger) flush_q <= 1'b0;
      else if (!nonempty)               flush_q <= 1'b0;
      else if (i_flush)                 flush_q <= 1'b1;

      if (state_q == StIdle && i_pkt_valid && o_pkt_ready && o_drop_cnt != 16'hFFFF) begin
        o_drop_cnt <= o_drop_cnt + 16'd1;
      end

      if (free) o_data_valid <= 1'b0;

      case (state_q)
        StIdle: begin
          if (trigger) begin
            state_q <= StConfHead;
            rem_q   <= n_load;
          end else if (i_pkt_valid && pkt_tag == 2'b01) begin
            state_q <= StPass;
          end
        end
        StPass: begin
          if (i_pkt_valid && free) begin
            o_data_valid <= 1'b1;
            o_data       <= i_pkt;
            if (pkt_tag == 2'b10) state_q <= StIdle;
          end
        end
        StConfHead: begin
          if (free) begin
            o_data_valid <= 1'b1;
            o_data       <= {2'b01, 4'h0, CONF_HEAD};
            state_q      <= StConfBody;
          end
        end
        StConfBody: begin
          if (free) begin
            o_data_valid <= 1'b1;
            o_data       <= body_beat;
            rem_q        <= rem_q - 8'd1;
            if (rem_q == 8'd1) begin
              state_q    <= StIdle;
              o_conf_cnt <= o_conf_cnt + 16'd1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conf_pkt_packer.sv
// Directed bench for conf_pkt_packer: bursts, timeout, flush, backpressure, full FIFO,
// arbitration against pass-through traffic and reset mid-packet.
module tb_conf_pkt_packer;

  localparam int unsigned MAX_WR     = 4;
  localparam int unsigned FIFO_DEPTH = 32;
  localparam int unsigned TIMEOUT    = 8;
  localparam logic [127:0] HEAD = {48'h8888_8888_8988, 48'h0102_0304_0506, 16'h9006, 16'h0};
  localparam logic [133:0] HEAD_BEAT = {2'b01, 4'h0, HEAD};

  logic         clk = 1'b0;
  logic         rst;
  logic         wr_valid, wr_ready, flush, pkt_valid, pkt_ready, data_valid, data_ready;
  logic [31:0]  wr_addr, wr_data;
  logic [133:0] pkt, data;
  logic [5:0]   fifo_cnt;
  logic [15:0]  conf_cnt, drop_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  conf_pkt_packer #(
    .MAX_WR    (MAX_WR),
    .FIFO_DEPTH(FIFO_DEPTH),
    .TIMEOUT   (TIMEOUT),
    .CONF_HEAD (HEAD)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_wr_valid  (wr_valid),
    .o_wr_ready  (wr_ready),
    .i_wr_addr   (wr_addr),
    .i_wr_data   (wr_data),
    .i_flush     (flush),
    .i_pkt_valid (pkt_valid),
    .i_pkt       (pkt),
    .o_pkt_ready (pkt_ready),
    .o_data_valid(data_valid),
    .o_data      (data),
    .i_data_ready(data_ready),
    .o_fifo_cnt  (fifo_cnt),
    .o_conf_cnt  (conf_cnt),
    .o_drop_cnt  (drop_cnt)
  );

  function automatic logic [133:0] wbeat(input logic [1:0] tg, input logic [31:0] a,
                                         input logic [31:0] d);
    return {tg, 4'hf, 48'h0, d, a, 16'h0};
  endfunction

  function automatic logic [133:0] pbeat(input logic [1:0] tg, input int i);
    return {tg, 4'hf, 96'h0, 32'hCAFE_0000 + 32'(i)};
  endfunction

  task automatic check(input string tag, input logic [133:0] obs, input logic [133:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push_n(input int n, input logic [31:0] a0, input logic [31:0] d0);
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_addr  = a0 + 32'(i);
      wr_data  = d0 + 32'(i);
      tick();
    end
    wr_valid = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, data_valid, 0);
    check({tag, "_data"}, data, 0);
    check({tag, "_fifo"}, fifo_cnt, 0);
    check({tag, "_conf"}, conf_cnt, 0);
    check({tag, "_drop"}, drop_cnt, 0);
    check({tag, "_wr_ready"}, wr_ready, 1);
    check({tag, "_pkt_ready"}, pkt_ready, 0);
  endtask

  initial begin
    int k;
    int heads;
    logic [1:0] tg;
    rst = 1'b1; wr_valid = 1'b0; wr_addr = '0; wr_data = '0; flush = 1'b0;
    pkt_valid = 1'b0; pkt = '0; data_ready = 1'b0;
    ticks(2);
    check_reset_state("reset");
    rst = 1'b0;
    data_ready = 1'b1;
    tick();

    // Full burst of MAX_WR writes
    push_n(4, 32'h0001_0200, 32'h0);
    tick();
    check("burst_gap", data_valid, 0);
    tick();
    check("burst_head", data, HEAD_BEAT);
    check("burst_head_valid", data_valid, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      tg = (i == 3) ? 2'b10 : 2'b00;
      check("burst_beat", data, wbeat(tg, 32'h0001_0200 + 32'(i), 32'(i)));
    end
    tick();
    check("burst_end_valid", data_valid, 0);
    check("burst_conf_cnt", conf_cnt, 1);
    check("burst_fifo_empty", fifo_cnt, 0);

    // Timeout flush of a partial packet
    push_n(2, 32'h20, 32'hA0);
    ticks(7);
    tick();
    check("timeout_not_early", data_valid, 0);
    tick();
    check("timeout_head", data, HEAD_BEAT);
    tick();
    check("timeout_beat0", data, wbeat(2'b00, 32'h20, 32'hA0));
    tick();
    check("timeout_tail", data, wbeat(2'b10, 32'h21, 32'hA1));
    check("timeout_conf_cnt", conf_cnt, 2);

    // Explicit flush with three queued writes
    push_n(3, 32'h30, 32'hB0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    tick();
    check("flush_gap", data_valid, 0);
    tick();
    check("flush_head", data, HEAD_BEAT);
    for (int i = 0; i < 3; i++) begin
      tick();
      tg = (i == 2) ? 2'b10 : 2'b00;
      check("flush_beat", data, wbeat(tg, 32'h30 + 32'(i), 32'hB0 + 32'(i)));
    end
    check("flush_conf_cnt", conf_cnt, 3);

    // Flush on an empty FIFO must not linger and fire on the next write
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    ticks(2);
    check("eflush_quiet", data_valid, 0);
    push_n(1, 32'h40, 32'hC0);
    ticks(2);
    check("eflush_no_early_pkt", data_valid, 0);
    check("eflush_fifo", fifo_cnt, 1);
    ticks(6);
    check("eflush_timeout_gap", data_valid, 0);
    tick();
    check("eflush_head", data, HEAD_BEAT);
    tick();
    check("eflush_tail", data, wbeat(2'b10, 32'h40, 32'hC0));
    check("eflush_conf_cnt", conf_cnt, 4);

    // Backpressure: 5-cycle stall mid-packet
    tick();
    push_n(4, 32'h50, 32'hD0);
    tick();
    tick();
    check("bp_head", data, HEAD_BEAT);
    tick();
    check("bp_beat0", data, wbeat(2'b00, 32'h50, 32'hD0));
    data_ready = 1'b0;
    ticks(3);
    check("bp_stall_data", data, wbeat(2'b00, 32'h50, 32'hD0));
    check("bp_stall_valid", data_valid, 1);
    ticks(2);
    check("bp_stall_data_end", data, wbeat(2'b00, 32'h50, 32'hD0));
    check("bp_stall_fifo", fifo_cnt, 3);
    data_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      tick();
      tg = (i == 3) ? 2'b10 : 2'b00;
      check("bp_beat", data, wbeat(tg, 32'h50 + 32'(i), 32'hD0 + 32'(i)));
    end
    tick();
    check("bp_end_valid", data_valid, 0);
    check("bp_conf_cnt", conf_cnt, 5);

    // Fill the FIFO while the output is stalled, then drain
    data_ready = 1'b0;
    for (int i = 0; i < 33; i++) begin
      wr_valid = 1'b1;
      wr_addr  = 32'h100 + 32'(i);
      wr_data  = 32'h1000 + 32'(i);
      tick();
      if (i == 31) begin
        check("full_wr_ready", wr_ready, 0);
        check("full_cnt", fifo_cnt, 32);
      end
    end
    wr_valid = 1'b0;
    check("full_no_overflow", fifo_cnt, 32);
    check("full_head_held", data, HEAD_BEAT);
    data_ready = 1'b1;
    k = 0;
    heads = 0;
    for (int c = 0; c < 70; c++) begin
      tick();
      if (data_valid) begin
        if (data[133:132] == 2'b01) begin
          check("drain_head", data, HEAD_BEAT);
          heads++;
        end else begin
          tg = (k % 4 == 3) ? 2'b10 : 2'b00;
          check("drain_beat", data, wbeat(tg, 32'h100 + 32'(k), 32'h1000 + 32'(k)));
          k++;
        end
      end
    end
    check("drain_beat_count", 134'(k), 32);
    check("drain_head_count", 134'(heads), 7);
    check("drain_conf_cnt", conf_cnt, 13);
    check("drain_fifo_empty", fifo_cnt, 0);

    // Pass-through packet in flight when the conf trigger arises
    tick();
    pkt_valid = 1'b1;
    pkt = pbeat(2'b01, 0);
    wr_valid = 1'b1; wr_addr = 32'h60; wr_data = 32'hE0;
    #1;
    check("idle_head_held", pkt_ready, 0);
    tick();
    check("pass_ready", pkt_ready, 1);
    wr_addr = 32'h61; wr_data = 32'hE1;
    tick();
    check("pass_beat0", data, pbeat(2'b01, 0));
    pkt = pbeat(2'b00, 1);
    wr_addr = 32'h62; wr_data = 32'hE2;
    tick();
    pkt = pbeat(2'b00, 2);
    wr_addr = 32'h63; wr_data = 32'hE3;
    tick();
    wr_valid = 1'b0;
    pkt = pbeat(2'b10, 3);
    check("pass_trig_fifo", fifo_cnt, 4);
    check("pass_beat2", data, pbeat(2'b00, 2));
    tick();
    pkt_valid = 1'b0;
    check("pass_tail", data, pbeat(2'b10, 3));
    tick();
    check("pass_conf_gap", data_valid, 0);
    tick();
    check("pass_then_conf_head", data, HEAD_BEAT);
    ticks(3);
    tick();
    check("pass_then_conf_tail", data, wbeat(2'b10, 32'h63, 32'hE3));
    check("pass_conf_cnt", conf_cnt, 14);

    // Pass-through head and trigger together: conf packet wins
    tick();
    push_n(4, 32'h70, 32'hF0);
    pkt_valid = 1'b1;
    pkt = pbeat(2'b01, 4);
    #1;
    check("prio_pkt_ready", pkt_ready, 0);
    tick();
    tick();
    check("prio_conf_head", data, HEAD_BEAT);
    ticks(3);
    tick();
    check("prio_conf_tail", data, wbeat(2'b10, 32'h73, 32'hF3));
    tick();
    check("prio_gap", data_valid, 0);
    tick();
    check("prio_pass_head", data, pbeat(2'b01, 4));
    pkt = pbeat(2'b10, 5);
    tick();
    check("prio_pass_tail", data, pbeat(2'b10, 5));
    pkt_valid = 1'b0;
    check("prio_conf_cnt", conf_cnt, 15);

    // Orphan body beat in IDLE is dropped
    pkt_valid = 1'b1;
    pkt = pbeat(2'b00, 6);
    #1;
    check("orphan_ready", pkt_ready, 1);
    tick();
    pkt_valid = 1'b0;
    check("orphan_drop_cnt", drop_cnt, 1);
    check("orphan_not_forwarded", data_valid, 0);

    // Reset in the middle of a conf packet
    push_n(4, 32'h80, 32'h90);
    ticks(2);
    check("rst_pre_head", data, HEAD_BEAT);
    tick();
    check("rst_pre_beat0", data, wbeat(2'b00, 32'h80, 32'h90));
    rst = 1'b1;
    tick();
    check_reset_state("midrst");
    rst = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      check("post_rst_quiet", data_valid, 0);
    end
    push_n(4, 32'hA0, 32'h10);
    tick();
    tick();
    check("post_rst_head", data, HEAD_BEAT);
    tick();
    check("post_rst_beat0", data, wbeat(2'b00, 32'hA0, 32'h10));
    check("post_rst_conf_cnt", conf_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
